// File: rtl/layer_generator.sv
// Row generator for a lane-hopping game: produces one seven-column row per jump,
// shaped by a Galois LFSR and a slowly rising hazard threshold.
module layer_generator #(
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          HAZARD_START   = 1,
  parameter int          HAZARD_MAX     = 6,
  parameter int          ROWS_PER_LEVEL = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       jump_left,
  input  logic       jump_right,
  output logic [0:6] layer_map_out,
  output logic [0:6] block_type_out,
  output logic       ready,
  output logic       overrun
);

  localparam int CNT_W = (ROWS_PER_LEVEL > 1) ? $clog2(ROWS_PER_LEVEL) : 1;
  localparam logic [CNT_W:0] ROWS_LIM  = (CNT_W + 1)'(ROWS_PER_LEVEL);
  localparam logic [2:0]     HAZ_START = 3'(HAZARD_START);
  localparam logic [2:0]     HAZ_MAX   = 3'(HAZARD_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Path wanders one column per row and bounces off the edges.
  function automatic logic [2:0] next_path(input logic [2:0] p, input logic dir);
    if (p == 3'd0)      return 3'd1;
    else if (p == 3'd6) return 3'd5;
    else if (dir)       return p + 3'd1;
    else                return p - 3'd1;
  endfunction

  state_t           state_r;
  logic [15:0]      lfsr_r;
  logic [2:0]       gen_cnt_r;
  logic [2:0]       path_col_r;
  logic [2:0]       hazard_level_r;
  logic [CNT_W-1:0] row_cnt_r;
  logic [0:6]       shadow_map_r;
  logic [0:6]       shadow_type_r;

  logic             jump_s;
  logic [2:0]       col_idx_s;
  logic             col_present_s;
  logic             col_hazard_s;
  logic [0:6]       build_map_s;
  logic [0:6]       build_type_s;
  logic [CNT_W:0]   row_next_s;

  assign jump_s     = jump_left | jump_right;
  assign row_next_s = {1'b0, row_cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // Build the column addressed by gen_cnt and merge it into the shadow row.
  always_comb begin
    col_idx_s     = gen_cnt_r - 3'd1;
    col_present_s = 1'b0;
    col_hazard_s  = 1'b0;
    build_map_s   = shadow_map_r;
    build_type_s  = shadow_type_r;
    if (col_idx_s == path_col_r) begin
      col_present_s = 1'b1;
      col_hazard_s  = 1'b0;
    end else begin
      col_present_s = (lfsr_r[2:0] < 3'd5);
      col_hazard_s  = col_present_s && (lfsr_r[5:3] < hazard_level_r);
    end
    for (int c = 0; c < 7; c++) begin
      if ((gen_cnt_r != 3'd0) && (col_idx_s == 3'(c))) begin
        build_map_s[c]  = col_present_s;
        build_type_s[c] = col_hazard_s;
      end else begin
        build_map_s[c]  = shadow_map_r[c];
        build_type_s[c] = shadow_type_r[c];
      end
    end
  end

  // Control FSM, LFSR, level tracking and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      lfsr_r         <= SEED;
      gen_cnt_r      <= 3'd0;
      path_col_r     <= 3'd3;
      hazard_level_r <= HAZ_START;
      row_cnt_r      <= {CNT_W{1'b0}};
      shadow_map_r   <= 7'b0000000;
      shadow_type_r  <= 7'b0000000;
      layer_map_out  <= 7'b0000000;
      block_type_out <= 7'b0000000;
      ready          <= 1'b0;
      overrun        <= 1'b0;
    end else if (!module_en) begin
      state_r        <= IDLE;
      lfsr_r         <= SEED;
      gen_cnt_r      <= 3'd0;
      path_col_r     <= 3'd3;
      hazard_level_r <= HAZ_START;
      row_cnt_r      <= {CNT_W{1'b0}};
      shadow_map_r   <= 7'b0000000;
      shadow_type_r  <= 7'b0000000;
      layer_map_out  <= 7'b0000000;
      block_type_out <= 7'b0000000;
      ready          <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r       <= GEN;
          gen_cnt_r     <= 3'd0;
          shadow_map_r  <= 7'b0000000;
          shadow_type_r <= 7'b0000000;
        end
        GEN: begin
          lfsr_r        <= lfsr_step(lfsr_r);
          shadow_map_r  <= build_map_s;
          shadow_type_r <= build_type_s;
          if (jump_s) begin
            overrun <= 1'b1;
          end
          if (gen_cnt_r == 3'd0) begin
            path_col_r <= next_path(path_col_r, lfsr_r[0]);
          end
          if (gen_cnt_r == 3'd7) begin
            // Whole row lands on the outputs in one edge.
            layer_map_out  <= build_map_s;
            block_type_out <= build_type_s;
            ready          <= 1'b1;
            state_r        <= READY;
            gen_cnt_r      <= 3'd0;
            if (row_next_s == ROWS_LIM) begin
              row_cnt_r <= {CNT_W{1'b0}};
              if (hazard_level_r < HAZ_MAX) begin
                hazard_level_r <= hazard_level_r + 3'd1;
              end
            end else begin
              row_cnt_r <= row_next_s[CNT_W-1:0];
            end
          end else begin
            gen_cnt_r <= gen_cnt_r + 3'd1;
          end
        end
        READY: begin
          if (jump_s) begin
            state_r       <= GEN;
            ready         <= 1'b0;
            gen_cnt_r     <= 3'd0;
            shadow_map_r  <= 7'b0000000;
            shadow_type_r <= 7'b0000000;
          end
        end
        default: begin
          state_r   <= IDLE;
          gen_cnt_r <= 3'd0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_generator.sv
// Directed bench for layer_generator: table-driven start-up, hand sequences for
// jump/overrun/reset corners, then a long run against a row-level reference model.
module tb_layer_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       module_en = 1'b0;
  logic       jump_left = 1'b0;
  logic       jump_right = 1'b0;
  logic [0:6] map0, type0, map1, type1;
  logic       ready0, ovr0, ready1, ovr1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  layer_generator #(.HAZARD_START(0), .ROWS_PER_LEVEL(8)) dut0 (
    .clk(clk), .rst(rst), .module_en(module_en),
    .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(map0), .block_type_out(type0),
    .ready(ready0), .overrun(ovr0)
  );

  layer_generator #(.HAZARD_START(0), .ROWS_PER_LEVEL(4096)) dut1 (
    .clk(clk), .rst(rst), .module_en(module_en),
    .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(map1), .block_type_out(type1),
    .ready(ready1), .overrun(ovr1)
  );

  typedef struct {
    logic       en;
    logic       jl;
    logic       jr;
    logic       exp_ready;
    logic       exp_ovr;
    logic [0:6] exp_map;
    logic [0:6] exp_type;
  } vec_t;

  vec_t vecs[11];

  // First row from SEED=ACE1, worked by hand: path 3->4, column 3 absent.
  localparam logic [0:6] ROW1_MAP = 7'b1110111;

  logic [15:0] m_lfsr;
  int          m_path, m_level, m_rows;
  logic [0:6]  m_map, m_type;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk7(input string name, input logic [0:6] act, input logic [0:6] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_path  = 3;
    m_level = 0;
    m_rows  = 0;
  endtask

  task automatic model_row();
    logic p, h;
    if (m_path == 0)      m_path = 1;
    else if (m_path == 6) m_path = 5;
    else if (m_lfsr[0])   m_path = m_path + 1;
    else                  m_path = m_path - 1;
    m_lfsr = lstep(m_lfsr);
    for (int c = 0; c < 7; c++) begin
      p = (m_lfsr[2:0] < 3'd5);
      h = p && (int'(m_lfsr[5:3]) < m_level);
      if (c == m_path) begin
        p = 1'b1;
        h = 1'b0;
      end
      m_map[c]  = p;
      m_type[c] = h;
      m_lfsr = lstep(m_lfsr);
    end
    m_rows++;
    if (m_rows == 8) begin
      m_rows = 0;
      if (m_level < 6) m_level++;
    end
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ready0) begin
        ok = 1'b1;
        break;
      end
    end
    chk1({name, "_ready_timeout"}, ok, 1'b1);
  endtask

  initial begin
    logic [0:6] old_map, old_type;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 7'b0000000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 7'b0000000};
    for (int i = 2; i < 9; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 7'b0000000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ROW1_MAP, 7'b0000000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ROW1_MAP, 7'b0000000};

    // Reset state
    step();
    step();
    chk7("rst_map", map0, 7'b0000000);
    chk7("rst_type", type0, 7'b0000000);
    chk1("rst_ready", ready0, 1'b0);
    chk1("rst_overrun", ovr0, 1'b0);
    rst = 1'b0;

    // Start-up table: IDLE jump ignored, first row on the 9th enabled edge
    model_reset();
    for (int i = 0; i < 11; i++) begin
      module_en  = vecs[i].en;
      jump_left  = vecs[i].jl;
      jump_right = vecs[i].jr;
      step();
      jump_left  = 1'b0;
      jump_right = 1'b0;
      chk1($sformatf("vec%0d_ready", i), ready0, vecs[i].exp_ready);
      chk1($sformatf("vec%0d_overrun", i), ovr0, vecs[i].exp_ovr);
      chk7($sformatf("vec%0d_map", i), map0, vecs[i].exp_map);
      chk7($sformatf("vec%0d_type", i), type0, vecs[i].exp_type);
    end
    model_row();
    chk7("row1_model_map", map0, m_map);

    // Both jump inputs together: one row, no overrun, old row held in jump cycle
    old_map = map0;
    old_type = type0;
    jump_left = 1'b1;
    jump_right = 1'b1;
    step();
    jump_left = 1'b0;
    jump_right = 1'b0;
    chk1("dual_jump_ready", ready0, 1'b0);
    chk7("dual_jump_hold_map", map0, old_map);
    chk7("dual_jump_hold_type", type0, old_type);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk1($sformatf("dual_gen%0d_ready", i), ready0, (i == 8));
      if (i < 8) chk7($sformatf("dual_gen%0d_map", i), map0, old_map);
    end
    model_row();
    chk7("row2_map", map0, m_map);
    chk7("row2_type", type0, m_type);
    chk1("dual_overrun", ovr0, 1'b0);

    // Second jump three cycles into GEN: sticky overrun, no extra row
    jump_left = 1'b1;
    step();
    jump_left = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) jump_right = 1'b1;
      step();
      jump_right = 1'b0;
      chk1($sformatf("ovr_gen%0d_ready", i), ready0, (i == 8));
      chk1($sformatf("ovr_gen%0d_overrun", i), ovr0, (i >= 3));
    end
    model_row();
    chk7("row3_map", map0, m_map);
    chk7("row3_type", type0, m_type);
    for (int i = 0; i < 10; i++) step();
    chk1("ovr_single_row_ready", ready0, 1'b1);
    chk7("ovr_single_row_map", map0, m_map);
    chk1("ovr_sticky", ovr0, 1'b1);

    // module_en drop during GEN abandons the row and restarts from SEED
    jump_left = 1'b1;
    step();
    jump_left = 1'b0;
    step();
    step();
    step();
    module_en = 1'b0;
    step();
    chk7("en_off_map", map0, 7'b0000000);
    chk7("en_off_type", type0, 7'b0000000);
    chk1("en_off_ready", ready0, 1'b0);
    chk1("en_off_overrun", ovr0, 1'b0);
    module_en = 1'b1;
    model_reset();
    for (int i = 1; i <= 9; i++) begin
      step();
      chk1($sformatf("restart%0d_ready", i), ready0, (i == 9));
    end
    chk7("restart_map", map0, ROW1_MAP);
    model_row();

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk7("async_rst_map", map0, 7'b0000000);
    chk7("async_rst_type", type0, 7'b0000000);
    chk1("async_rst_ready", ready0, 1'b0);
    module_en = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk7("post_rst_map", map0, 7'b0000000);
    chk1("post_rst_ready", ready0, 1'b0);

    // Long run against the reference model, 1000 rows
    module_en = 1'b1;
    model_reset();
    wait_ready("long_first");
    for (int r = 0; r < 1000; r++) begin
      if (r > 0) begin
        jump_left = r[0];
        jump_right = ~r[0];
        step();
        jump_left = 1'b0;
        jump_right = 1'b0;
        wait_ready($sformatf("long%0d", r));
      end
      model_row();
      chk7($sformatf("long%0d_map", r), map0, m_map);
      chk7($sformatf("long%0d_type", r), type0, m_type);
      chk7($sformatf("long%0d_haz_on_absent", r), type0 & ~map0, 7'b0000000);
      chk7($sformatf("long%0d_nohaz_type", r), type1, 7'b0000000);
      chk7($sformatf("long%0d_nohaz_map", r), map1, m_map);
    end
    chk1("long_overrun", ovr0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_generator.md
LAYER_GENERATOR -- requirements
Module: layer_generator

Interface
REQ-001 Parameter SEED, default 16'hACE1, initial LFSR value (nonzero).
REQ-002 Parameter HAZARD_START, default 1, initial hazard threshold (0..7).
REQ-003 Parameter HAZARD_MAX, default 6, hazard threshold ceiling (0..7).
REQ-004 Parameter ROWS_PER_LEVEL, default 8, rows generated per difficulty step.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 module_en  input  1  game-active enable; low holds the block in its reset state.
REQ-008 jump_left  input  1  one-cycle jump pulse.
REQ-009 jump_right  input  1  one-cycle jump pulse.
REQ-010 layer_map_out  output  [0:6]  block-present bit per column, feeds the layer_map_in input of the block-rendering stage.
REQ-011 block_type_out  output  [0:6]  hazard bit per column (1 = failing block), feeds the matching block_type_in input.
REQ-012 ready  output  1  a complete new row is held on the outputs.
REQ-013 overrun  output  1  sticky; a jump arrived while a row was still being generated.

Function
REQ-014 The block SHALL use a 16-bit Galois LFSR: shift right, XOR mask 16'hB400 when the bit shifted out is 1; it steps exactly once per GEN cycle and holds otherwise.
REQ-015 The FSM SHALL have states IDLE, GEN, READY; rst or module_en=0 forces IDLE.
REQ-016 IDLE -> GEN when module_en=1; gen_cnt=0.
REQ-017 GEN lasts exactly 8 cycles (gen_cnt 0..7), then READY.
REQ-018 At gen_cnt=0, path_col SHALL update: lfsr[0]=1 -> +1, else -1; path_col=0 forces +1 and path_col=6 forces -1; range stays 0..6.
REQ-019 At gen_cnt=k (1..7), column c=k-1 is built in a shadow row.
REQ-020 Column build: present = (lfsr[2:0] < 5); hazard = present AND (lfsr[5:3] < hazard_level).
REQ-021 Column c == path_col SHALL be forced to present=1, hazard=0.
REQ-022 Every non-present column SHALL have hazard=0.
REQ-023 At the gen_cnt=7 edge, the shadow row SHALL be copied atomically to both outputs; partial rows are never visible.
REQ-024 ready SHALL be 1 only in READY, and only after that copy.
REQ-025 A jump is jump_left OR jump_right; both high in one cycle counts as one jump.
REQ-026 A jump in READY -> GEN on that edge, ready=0; the outputs keep the old row until the next commit, so the downstream latch captures the old row in the jump cycle.
REQ-027 A jump in GEN SHALL set overrun, leave the FSM and gen_cnt unchanged, and not queue a second row.
REQ-028 A jump in IDLE SHALL be ignored.
REQ-029 Each commit SHALL increment a row counter.
REQ-030 When the row counter reaches ROWS_PER_LEVEL, it returns to 0 and hazard_level increments, saturating at HAZARD_MAX.
REQ-031 overrun SHALL clear only on reset or module_en=0.

Reset
REQ-032 On rst=1, asynchronously and regardless of clk: lfsr=SEED, path_col=3, hazard_level=HAZARD_START, row counter=0, gen_cnt=0, state=IDLE, layer_map_out=0, block_type_out=0, ready=0, overrun=0.
REQ-033 module_en=0 SHALL apply the same values synchronously on the next edge.
REQ-034 Reset or module_en=0 during GEN SHALL abandon the partial row, with no commit.

Verification
REQ-035 rst pulse mid-cycle -> all outputs 0 immediately, before the next edge; after release with module_en=0, outputs stay 0 and ready=0.
REQ-036 module_en 0->1 -> ready=1 on the 9th edge counting the first edge that samples module_en=1; on that row, layer_map_out[path_col]=1 and block_type_out[path_col]=0, with path_col equal to 2 or 4.
REQ-037 Jump pulse with ready=1 -> outputs unchanged in the jump cycle; ready=0 for 8 cycles; new row committed on the 9th edge; path_col changed by exactly 1.
REQ-038 Second jump 3 cycles after the first -> overrun=1 and stays 1; commit still lands 9 edges after the first jump; only one new row is produced.
REQ-039 HAZARD_START=0, 1000 rows -> block_type_out=0 throughout with ROWS_PER_LEVEL large; with ROWS_PER_LEVEL=8, hazard_level reaches 6 after 48 rows and stays at 6; across all rows, no bit with block_type_out=1 has layer_map_out=0.
REQ-040 Force path_col=6 or path_col=0 -> next value is 5 or 1 respectively; jump_left=jump_right=1 together -> exactly one row generated, and overrun stays 0.
